multiply_sign_restore: RTL and testbench
========================================

// Module: multiply_sign_restore
// PURPOSE
//  Back end of the signed-multiply datapath: takes the unsigned magnitude product and the result
//  sign (sign_a ^ sign_b) and rebuilds the two's-complement signed result.
//  Negation is ~mag + 1, done chunk-serially on a narrow XOR/adder slice with the carry held
//  between cycles. Start/busy/done handshake to the calculator controller; flags out-of-range results.
// PARAMETERS
//  W      16  result/magnitude width in bits; must be a multiple of CHUNK
//  CHUNK  8   adder slice width processed per cycle; NCH = W/CHUNK slices
// PORTS
//  clk     in   1  rising-edge clock
//  rst_n   in   1  asynchronous reset, active low
//  start   in   1  request; sampled only when busy=0
//  mag     in   W  unsigned product magnitude; captured with start
//  neg     in   1  1 = result negative; captured with start
//  busy    out  1  high from the cycle after start is accepted until done
//  done    out  1  one-cycle pulse; result and ovf are valid from this cycle
//  result  out  W  signed two's-complement result; held until the next done
//  ovf     out  1  result not representable in W-bit signed; valid with done, held with result
// BEHAVIOUR
//  Reset (async, rst_n=0): busy=0, done=0, result=0, ovf=0, carry=0, slice idx=0, state IDLE.
//  States: IDLE -> RUN (NCH cycles) -> DONE (1 cycle) -> IDLE.
//  - IDLE: start=1 captures mag and neg, sets carry=neg, idx=0, goes to RUN. busy=1 next cycle.
//  - RUN: slice idx: res[idx] = (mag[idx] ^ {CHUNK{neg}}) + carry. Next carry is the slice carry-out.
//    idx advances each cycle. After slice NCH-1, go to DONE.
//  - DONE: done=1, busy=0, result and ovf registered. Next state is IDLE.
//  Latency: start sampled in cycle t -> done high in cycle t+NCH+1, for both signs
//  (positive path uses mask 0 / carry 0). For W=16: t+3.
//  A start in the DONE cycle is ignored. A new start is accepted the cycle after done.
//  start while busy=1: ignored, with no effect on the operation in flight.
//  Carry out of the top slice is discarded. mag=0, neg=1 -> result 0, ovf=0.
//  ovf, computed from the captured mag:
//    neg=0: ovf = mag[W-1].
//    neg=1: ovf = mag[W-1] & |mag[W-2:0]. mag=2^(W-1) is legal (most negative value).
//  On ovf the result still holds the wrapped W-bit value.
//  rst_n low mid-RUN: operation abandoned, all outputs return to reset values, no done issued.
//  result changes only at the DONE cycle or at reset. No combinational input->output paths.
// STRUCTURE
//  Shared package (mult_pkg): state encodings (IDLE/RUN/DONE), default W=16, CHUNK=8.
//  Sub-module chunk_xor_adder: combinational CHUNK-bit slice.
//    Inputs: a, mask bit, ci. Outputs: (a ^ {CHUNK{mask}}) + ci, and co.
//    Built as a ripple chain of the existing full_adder cell logic.
//  Top level holds the FSM, idx counter, carry register, captured operands, and result/ovf registers.
// TESTING (W=16, CHUNK=8)
//  1. mag=0x0F00, neg=0, start in cycle t -> busy t+1..t+2; done t+3; result=0x0F00, ovf=0.
//  2. mag=0x0F00, neg=1 -> result=0xF100, ovf=0.
//     mag=0x0100, neg=1 -> 0xFF00 (carry crosses the slice boundary).
//  3. mag=0x0000, neg=1 -> result=0x0000, ovf=0.
//     mag=0x8000, neg=1 -> result=0x8000, ovf=0.
//  4. mag=0x8000, neg=0 -> ovf=1, result=0x8000.
//     mag=0x8001, neg=1 -> ovf=1, result=0x7FFF.
//  5. start pulsed at t+1 and t+2 during busy with other mag -> ignored;
//     the first operation's result arrives at t+3; exactly one done pulse.
//  6. rst_n low at t+2 -> all outputs 0 immediately; no done.
//     start after release -> normal 3-cycle operation.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default widths for the signed-multiply back end
package mult_pkg;
  localparam int W_DEF = 16;
  localparam int CHUNK_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/chunk_xor_adder.sv
// chunk_xor_adder: combinational CHUNK-bit slice computing (a ^ {CHUNK{mask}}) + ci
//   a    in  CHUNK  slice of the magnitude
//   mask in  1      invert the slice (negative result)
//   ci   in  1      carry in from the previous slice
//   sum  out CHUNK  slice result
//   co   out 1      carry out to the next slice
module chunk_xor_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic             mask,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    logic x;
    // full adder with the second operand tied to 0
    assign x = a[g] ^ mask;
    assign sum[g] = x ^ c[g];
    assign c[g+1] = x & c[g];
  end
  assign co = c[CHUNK];
endmodule

// File: rtl/multiply_sign_restore.sv
// multiply_sign_restore: rebuilds a signed two's-complement result from magnitude and sign, chunk-serially
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous reset, active low
//   start  in  1  request, sampled only while idle
//   mag    in  W  unsigned product magnitude, captured with start
//   neg    in  1  result negative, captured with start
//   busy   out 1  operation in flight
//   done   out 1  one-cycle pulse, result/ovf valid
//   result out W  signed result, held until the next done
//   ovf    out 1  result not representable in W-bit signed
module multiply_sign_restore
  import mult_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] mag,
  input  logic         neg,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);
  localparam int NCH = W / CHUNK;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  state_t state;
  logic [IW-1:0] idx;
  logic carry, neg_r, co, ovf_c;
  logic [W-1:0] mag_r, acc, next_acc;
  logic [CHUNK-1:0] sum;
  chunk_xor_adder #(.CHUNK(CHUNK)) u_slice (
    .a(mag_r[idx*CHUNK +: CHUNK]),
    .mask(neg_r),
    .ci(carry),
    .sum(sum),
    .co(co)
  );
  always_comb begin
    next_acc = acc;
    next_acc[idx*CHUNK +: CHUNK] = sum;
  end
  // the most negative value 2^(W-1) is representable when negated
  assign ovf_c = neg_r ? (mag_r[W-1] & |mag_r[W-2:0]) : mag_r[W-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      neg_r <= 1'b0;
      mag_r <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mag_r <= mag;
          neg_r <= neg;
          carry <= neg;
          idx <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= next_acc;
          carry <= co;
          idx <= idx + IW'(1);
          if (idx == IW'(NCH - 1)) begin
            result <= next_acc;
            ovf <= ovf_c;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiply_sign_restore.sv
// tb_multiply_sign_restore: scoreboard bench with directed vectors for multiply_sign_restore
module tb_multiply_sign_restore;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [15:0] mag = '0;
  logic neg = 1'b0;
  logic busy, done, ovf;
  logic [15:0] result;
  logic [16:0] q[$];
  int total = 0;
  int passed = 0;
  int dones = 0;
  int expected_dones = 0;
  multiply_sign_restore #(.W(16), .CHUNK(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mag(mag),
    .neg(neg),
    .busy(busy),
    .done(done),
    .result(result),
    .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [16:0] e;
      dones++;
      if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e[16:1]));
        check("ovf", 32'(ovf), 32'(e[0]));
      end
    end
  end
  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle
  task automatic op(input logic [15:0] m, input logic n, input logic [15:0] er, input logic eo, input bit poke);
    start = 1'b1;
    mag = m;
    neg = n;
    q.push_back({er, eo});
    expected_dones++;
    @(negedge clk);
    start = poke;
    mag = m ^ 16'h5a5a;
    neg = ~n;
    check("busy_t1", 32'(busy), 32'd1);
    check("done_t1", 32'(done), 32'd0);
    @(negedge clk);
    check("busy_t2", 32'(busy), 32'd1);
    check("done_t2", 32'(done), 32'd0);
    @(negedge clk);
    check("done_t3", 32'(done), 32'd1);
    check("busy_t3", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("done_t4", 32'(done), 32'd0);
    check("busy_t4", 32'(busy), 32'd0);
    check("result_held", 32'(result), 32'(er));
    check("ovf_held", 32'(ovf), 32'(eo));
  endtask
  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(16'h0F00, 1'b0, 16'h0F00, 1'b0, 1'b0);
    op(16'h0F00, 1'b1, 16'hF100, 1'b0, 1'b0);
    op(16'h0100, 1'b1, 16'hFF00, 1'b0, 1'b0);
    op(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    op(16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0);
    op(16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0);
    op(16'h8001, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    op(16'h00FF, 1'b1, 16'hFF01, 1'b0, 1'b1);
    op(16'h1234, 1'b1, 16'hEDCC, 1'b0, 1'b1);
    op(16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0);
    start = 1'b1;
    mag = 16'h4321;
    neg = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);
    op(16'h0003, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("done_count", 32'(dones), 32'(expected_dones));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
